// File: rtl/sd_sector_xfer.sv
// Moves N 512-byte sectors between the MiSTer SD block port and a 16-bit local memory through a 256x16 buffer.
// One memory word per mem_ready; host ack timing and mem_ready stalls hold the FSM in place, nothing is dropped.
module sd_sector_xfer #(
   parameter int MEM_AW = 18,
   parameter int CNT_W  = 8
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              img_mounted,
   input  logic              start_rd,
   input  logic              start_wr,
   input  logic [31:0]       req_lba,
   input  logic [CNT_W-1:0]  req_cnt,
   input  logic [MEM_AW-1:0] req_base,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,
   input  logic [7:0]        sd_buff_addr,
   input  logic [15:0]       sd_buff_dout,
   input  logic              sd_buff_wr,
   output logic [15:0]       sd_buff_din,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_we,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready
);
   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_XFER, RD_COPY, WR_FILL, WR_REQ, WR_XFER, FIN
   } state_t;

   typedef struct packed {
      logic [31:0]       lba;
      logic [CNT_W-1:0]  left;
      logic [MEM_AW-1:0] base;
   } ctx_t;

   state_t      state, state_nxt;
   ctx_t        ctx;
   logic        mounted, err_q, ack_q;
   logic [7:0]  word_idx;
   logic [15:0] sec_buf [256];

   logic start_any, reject, ack_fall, last_word, more_secs, mem_phase;

   assign start_any = start_rd | start_wr;
   assign reject    = ~mounted | (req_cnt == '0);
   assign ack_fall  = ack_q & ~sd_ack;
   assign last_word = (word_idx == 8'hFF);
   assign more_secs = (ctx.left > CNT_W'(1));
   assign mem_phase = (state == RD_COPY) || (state == WR_FILL);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_any) begin
               if (reject)        state_nxt = FIN;
               else if (start_rd) state_nxt = RD_REQ;
               else               state_nxt = WR_FILL;
            end
         end
         RD_REQ:  if (sd_ack) state_nxt = RD_XFER;
         RD_XFER: if (ack_fall) state_nxt = RD_COPY;
         RD_COPY: if (mem_ready && last_word) state_nxt = more_secs ? RD_REQ : FIN;
         WR_FILL: if (mem_ready && last_word) state_nxt = WR_REQ;
         WR_REQ:  if (sd_ack) state_nxt = WR_XFER;
         WR_XFER: if (ack_fall) state_nxt = more_secs ? WR_FILL : FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == FIN);
      err       = (state == FIN) & err_q;
      sd_lba    = ctx.lba;
      sd_rd     = (state == RD_REQ);
      sd_wr     = (state == WR_REQ);
      mem_we    = (state == RD_COPY);
      mem_rd    = (state == WR_FILL);
      mem_addr  = mem_phase ? ctx.base + MEM_AW'(word_idx) : '0;
      mem_wdata = (state == RD_COPY) ? sec_buf[word_idx] : '0;
   end

   // Context is only replaced on an accepted request so sd_lba stays put on rejects.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mounted  <= 1'b0;
         err_q    <= 1'b0;
         ack_q    <= 1'b0;
         ctx      <= '0;
         word_idx <= '0;
      end else begin
         ack_q <= sd_ack;
         if (img_mounted) mounted <= 1'b1;
         if (state == IDLE) begin
            word_idx <= '0;
            if (start_any) begin
               err_q <= ~mounted;
               if (!reject) ctx <= '{lba: req_lba, left: req_cnt, base: req_base};
            end
         end
         if (mem_phase && mem_ready) word_idx <= word_idx + 8'd1;
         if ((state == RD_COPY && mem_ready && last_word && more_secs) ||
             (state == WR_XFER && ack_fall && more_secs))
            ctx <= '{lba: ctx.lba + 32'd1, left: ctx.left - CNT_W'(1), base: ctx.base + MEM_AW'(256)};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (state == RD_XFER && sd_buff_wr)
         sec_buf[sd_buff_addr] <= sd_buff_dout;
      else if (state == WR_FILL && mem_ready)
         sec_buf[word_idx] <= mem_rdata;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) sd_buff_din <= '0;
      else          sd_buff_din <= sec_buf[sd_buff_addr];
   end
endmodule

// File: tb/tb_sd_sector_xfer.sv
// Randomized scoreboard bench for sd_sector_xfer: SD host, memory responder and monitor run as separate processes.
module tb_sd_sector_xfer;
   localparam int MEM_AW    = 18;
   localparam int CNT_W     = 8;
   localparam int MEM_WORDS = 1 << MEM_AW;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              img_mounted = 1'b0, start_rd = 1'b0, start_wr = 1'b0;
   logic [31:0]       req_lba = '0;
   logic [CNT_W-1:0]  req_cnt = '0;
   logic [MEM_AW-1:0] req_base = '0;
   logic              busy, done, err, sd_rd, sd_wr, mem_rd, mem_we;
   logic [31:0]       sd_lba;
   logic              sd_ack = 1'b0, sd_buff_wr = 1'b0, mem_ready = 1'b0;
   logic [7:0]        sd_buff_addr = '0;
   logic [15:0]       sd_buff_dout = '0, sd_buff_din, mem_wdata, mem_rdata = '0;
   logic [MEM_AW-1:0] mem_addr;

   sd_sector_xfer #(.MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .img_mounted(img_mounted),
      .start_rd(start_rd), .start_wr(start_wr), .req_lba(req_lba), .req_cnt(req_cnt),
      .req_base(req_base), .busy(busy), .done(done), .err(err), .sd_lba(sd_lba),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed { logic [MEM_AW-1:0] addr; logic [15:0] data; } mem_exp_t;
   typedef struct packed { logic wr; logic [31:0] lba; } sd_exp_t;

   mem_exp_t    exp_mem_q[$];
   sd_exp_t     exp_sd_q[$];
   logic [15:0] exp_host_q[$];
   logic        exp_err_q[$];
   logic [15:0] mem_model [MEM_WORDS];

   int   checks = 0, errors = 0;
   int   ready_mode = 0, mem_wr_cnt = 0, mem_rd_cnt = 0, sd_req_cnt = 0, last_lat = 0;
   logic mounted_m = 1'b0, host_abort = 1'b0, hit100 = 1'b0;
   logic [15:0] host_key = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Host sector content: word index mixed with the sector number under a per-request key.
   function automatic logic [15:0] hdata(input logic [31:0] lba, input int i, input logic [15:0] key);
      return 16'(i) ^ 16'(lba[15:0] * key);
   endfunction

   // Memory responder: ready pattern chosen by ready_mode, read data follows the current address.
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk_sys); #1;
         phase++;
         case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = ((phase % 4) == 3);
         endcase
         mem_rdata = mem_rd ? mem_model[mem_addr] : 16'h0;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a memory write, an SD request or done.
   initial begin
      logic prev_rd, prev_wr;
      mem_exp_t me;
      sd_exp_t  se;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset_n) begin
            if (mem_we && mem_ready) begin
               mem_wr_cnt++;
               if (exp_mem_q.size() == 0) check("mem_write_expected", 0, 1);
               else begin
                  me = exp_mem_q.pop_front();
                  check("mem_waddr", mem_addr, me.addr);
                  check("mem_wdata", mem_wdata, me.data);
               end
               mem_model[mem_addr] = mem_wdata;
            end
            if (mem_rd && mem_ready) mem_rd_cnt++;
            if ((sd_rd && !prev_rd) || (sd_wr && !prev_wr)) begin
               sd_req_cnt++;
               if (exp_sd_q.size() == 0) check("sd_request_expected", 0, 1);
               else begin
                  se = exp_sd_q.pop_front();
                  check("sd_dir_is_wr", sd_wr, se.wr);
                  check("sd_lba", sd_lba, se.lba);
               end
            end
            if (done) begin
               if (exp_err_q.size() == 0) check("done_expected", 0, 1);
               else check("err_with_done", err, exp_err_q.pop_front());
            end
         end
         prev_rd = sd_rd;
         prev_wr = sd_wr;
      end
   end

   // SD host: serves each sd_rd / sd_wr request with one 256-word sector.
   initial begin
      logic        is_rd, aborted;
      logic [31:0] cur;
      logic [15:0] cap;
      forever begin
         @(negedge clk_sys);
         if (reset_n && (sd_rd || sd_wr)) begin
            is_rd = sd_rd;
            cur = sd_lba;
            aborted = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk_sys);
            @(posedge clk_sys); #1 sd_ack = 1'b1;
            @(posedge clk_sys); @(negedge clk_sys);
            check(is_rd ? "sd_rd_drops_on_ack" : "sd_wr_drops_on_ack", is_rd ? sd_rd : sd_wr, 0);
            for (int i = 0; i < 256; i++) begin
               if (is_rd) begin
                  if ($urandom_range(0, 3) == 0) begin
                     @(posedge clk_sys); #1 sd_buff_wr = 1'b0;
                  end
                  @(posedge clk_sys); #1;
                  sd_buff_addr = 8'(i);
                  sd_buff_dout = hdata(cur, i, host_key);
                  sd_buff_wr   = 1'b1;
                  if (host_abort && i == 100) begin
                     hit100 = 1'b1;
                     for (int k = 0; k < 200 && reset_n; k++) @(posedge clk_sys);
                     repeat (8) @(posedge clk_sys);
                     aborted = 1'b1;
                     break;
                  end
               end else begin
                  // Occasionally strobe garbage into the word about to be read; it must not land.
                  if ($urandom_range(0, 2) == 0) begin
                     @(posedge clk_sys); #1;
                     sd_buff_addr = 8'(i); sd_buff_dout = 16'hDEAD; sd_buff_wr = 1'b1;
                     @(posedge clk_sys); #1 sd_buff_wr = 1'b0;
                  end else begin
                     @(posedge clk_sys); #1 sd_buff_addr = 8'(i);
                  end
                  @(posedge clk_sys); @(negedge clk_sys);
                  cap = sd_buff_din;
                  if (exp_host_q.size() == 0) check("host_word_expected", 0, 1);
                  else check("host_rdata", cap, exp_host_q.pop_front());
               end
            end
            if (!aborted) begin
               @(posedge clk_sys); #1 sd_buff_wr = 1'b0;
               repeat ($urandom_range(0, 2)) @(posedge clk_sys);
            end
            @(posedge clk_sys); #1;
            sd_ack = 1'b0;
            sd_buff_wr = 1'b0;
            hit100 = 1'b0;
         end
      end
   end

   task automatic mount();
      @(posedge clk_sys); #1 img_mounted = 1'b1;
      @(posedge clk_sys); #1 img_mounted = 1'b0;
      mounted_m = 1'b1;
   endtask

   task automatic issue_req(input bit rd, input bit wr, input logic [31:0] lba, input int cnt,
                            input logic [MEM_AW-1:0] base);
      logic [31:0] sl;
      sd_exp_t     se;
      mem_exp_t    me;
      int          a;
      exp_err_q.push_back(!mounted_m);
      if (mounted_m && cnt != 0) begin
         for (int s = 0; s < cnt; s++) begin
            sl = lba + 32'(s);
            se.wr = !rd;
            se.lba = sl;
            exp_sd_q.push_back(se);
            for (int i = 0; i < 256; i++) begin
               a = (int'(base) + s * 256 + i) % MEM_WORDS;
               if (rd) begin
                  me.addr = MEM_AW'(a);
                  me.data = hdata(sl, i, host_key);
                  exp_mem_q.push_back(me);
               end else begin
                  exp_host_q.push_back(mem_model[a]);
               end
            end
         end
      end
      @(posedge clk_sys); #1;
      start_rd = rd; start_wr = wr; req_lba = lba; req_cnt = CNT_W'(cnt); req_base = base;
      @(posedge clk_sys); #1;
      start_rd = 1'b0; start_wr = 1'b0;
      @(negedge clk_sys);
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input bit poke);
      int n;
      n = 0;
      while (!done && n < 20000) begin
         if (poke && n == 20) begin start_wr = 1'b1; req_lba = ~req_lba; end
         if (n == 21) start_wr = 1'b0;
         @(negedge clk_sys);
         n++;
      end
      start_wr = 1'b0;
      last_lat = n;
      check("done_seen", done, 1);
      @(negedge clk_sys);
      check("done_single_cycle", done, 0);
      check("busy_after_done", busy, 0);
   endtask

   initial begin
      int          n, w0, r0, s0, cnt;
      bit          rd;
      logic [31:0] lba;
      logic [MEM_AW-1:0] base;
      for (int a = 0; a < MEM_WORDS; a++) mem_model[a] = 16'($urandom);

      repeat (3) @(negedge clk_sys);
      check("rst_busy", busy, 0);       check("rst_done", done, 0);
      check("rst_err", err, 0);         check("rst_sd_rd", sd_rd, 0);
      check("rst_sd_wr", sd_wr, 0);     check("rst_sd_lba", sd_lba, 0);
      check("rst_mem_we", mem_we, 0);   check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_sd_buff_din", sd_buff_din, 0);
      @(posedge clk_sys); #1 reset_n = 1'b1;

      // Not mounted: rejected with err, no SD request.
      issue_req(1, 0, 32'd9, 1, '0);
      wait_done(0);
      check("reject_done_latency", last_lat, 0);
      mount();

      // Two-sector read with data = word index; a start_wr while busy must be ignored.
      host_key = 16'h0;
      issue_req(1, 0, 32'd5, 2, 18'h100);
      wait_done(1);

      // One-sector write of a known pattern.
      for (int i = 0; i < 256; i++) mem_model[i] = 16'hA500 + 16'(i);
      issue_req(0, 1, 32'd0, 1, 18'h0);
      wait_done(0);

      // Zero count: done without SD or memory activity.
      w0 = mem_wr_cnt; r0 = mem_rd_cnt; s0 = sd_req_cnt;
      issue_req(1, 0, 32'd7, 0, 18'h55);
      wait_done(0);
      check("cnt0_no_mem_wr", mem_wr_cnt, w0);
      check("cnt0_no_mem_rd", mem_rd_cnt, r0);
      check("cnt0_no_sd_req", sd_req_cnt, s0);

      // Simultaneous starts: the read wins.
      host_key = 16'($urandom);
      issue_req(1, 1, 32'd20, 1, 18'h2000);
      wait_done(0);

      // Slow memory: ready one cycle in four.
      ready_mode = 2;
      issue_req(1, 0, 32'd100, 2, 18'h3000);
      wait_done(0);
      ready_mode = 0;

      // Reset in the middle of a host transfer.
      host_abort = 1'b1;
      issue_req(1, 0, 32'h40, 1, 18'h0);
      n = 0;
      while (!hit100 && n < 5000) begin @(negedge clk_sys); n++; end
      check("abort_point_reached", hit100, 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_sd_rd", sd_rd, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      exp_mem_q.delete(); exp_sd_q.delete(); exp_err_q.delete(); exp_host_q.delete();
      mounted_m = 1'b0;
      host_abort = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("abort_hold_done", done, 0);
      @(posedge clk_sys); #1 reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("post_reset_busy", busy, 0);
      check("post_reset_sd_rd", sd_rd, 0);
      repeat (12) @(negedge clk_sys);
      mount();
      issue_req(1, 0, 32'h41, 1, 18'h800);
      wait_done(0);

      // Randomized requests including LBA and memory-address wrap.
      for (int r = 0; r < 8; r++) begin
         rd = 1'($urandom_range(0, 1));
         lba = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 1)) : 32'($urandom);
         base = ($urandom_range(0, 2) == 0) ? 18'h3FF00 + 18'($urandom_range(0, 255)) : 18'($urandom);
         cnt = $urandom_range(1, 2);
         ready_mode = $urandom_range(0, 2);
         host_key = 16'($urandom);
         issue_req(rd, !rd, lba, cnt, base);
         wait_done(0);
      end

      check("exp_mem_q_drained", exp_mem_q.size(), 0);
      check("exp_sd_q_drained", exp_sd_q.size(), 0);
      check("exp_host_q_drained", exp_host_q.size(), 0);
      check("exp_err_q_drained", exp_err_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
